// File: rtl/sattn_cmd_dispatch.sv
// sattn_cmd_dispatch
//   MMIO command front-end for the sparse-attention engines. Command words
//   are pushed into a QDEPTH-entry FIFO and dispatched strictly in order to
//   NUM_ENG engines. Each engine has a busy bit, a latched tag and a watchdog
//   counter. The block keeps a saturating completion counter, the tag/engine
//   of the most recent completion, three sticky error flags (overflow,
//   timeout, bad engine) and a registered level interrupt.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   mmio_wen           register write strobe
//   mmio_addr          register byte offset
//   mmio_wdata         write data
//   mmio_rdata         combinational read data for mmio_addr
//   eng_start          one-cycle start pulse per engine (registered)
//   eng_opcode         opcode of the command being started
//   eng_done           one-cycle completion pulse per engine
//   irq                level interrupt
//
// Register map (byte offsets)
//   0x00 CMD W  {eng[18:16], tag[15:8], opcode[7:0]}
//   0x08 STATUS R  [0] empty [1] full [15:8] busy [23:16] count
//                  [32] overflow [33] timeout [34] bad_eng
//   0x10 DONE_CNT R   0x18 LAST_TAG R   0x20 IRQ_EN RW
//   0x28 CLEAR W (bit0 stickies, bit1 DONE_CNT)   0x30 TO_THRESH RW
module sattn_cmd_dispatch #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_ENG    = 4,
  parameter int QDEPTH     = 8,
  parameter int TO_W       = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mmio_wen,
  input  logic [ADDR_WIDTH-1:0] mmio_addr,
  input  logic [DATA_WIDTH-1:0] mmio_wdata,
  output logic [DATA_WIDTH-1:0] mmio_rdata,
  output logic [NUM_ENG-1:0]    eng_start,
  output logic [7:0]            eng_opcode,
  input  logic [NUM_ENG-1:0]    eng_done,
  output logic                  irq
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH) + 1;

  localparam logic [ADDR_WIDTH-1:0] A_CMD    = ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(32'h08);
  localparam logic [ADDR_WIDTH-1:0] A_DCNT   = ADDR_WIDTH'(32'h10);
  localparam logic [ADDR_WIDTH-1:0] A_LTAG   = ADDR_WIDTH'(32'h18);
  localparam logic [ADDR_WIDTH-1:0] A_IRQEN  = ADDR_WIDTH'(32'h20);
  localparam logic [ADDR_WIDTH-1:0] A_CLEAR  = ADDR_WIDTH'(32'h28);
  localparam logic [ADDR_WIDTH-1:0] A_THRESH = ADDR_WIDTH'(32'h30);

  typedef struct packed {
    logic [2:0] eng;
    logic [7:0] tag;
    logic [7:0] op;
  } cmd_t;

  // Register write decode
  logic wr_cmd, wr_irq_en, wr_clear, wr_thresh, clr_st, clr_cnt;
  logic unused_wdata;

  assign wr_cmd    = mmio_wen && (mmio_addr == A_CMD);
  assign wr_irq_en = mmio_wen && (mmio_addr == A_IRQEN);
  assign wr_clear  = mmio_wen && (mmio_addr == A_CLEAR);
  assign wr_thresh = mmio_wen && (mmio_addr == A_THRESH);
  assign clr_st    = wr_clear && mmio_wdata[0];
  assign clr_cnt   = wr_clear && mmio_wdata[1];
  assign unused_wdata = ^mmio_wdata;

  // Control state
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_ENG-1:0] busy_q, busy_d;
  logic [TO_W-1:0]    wd_q [NUM_ENG];
  logic [TO_W-1:0]    wd_d [NUM_ENG];
  logic [31:0]        done_cnt_q, done_cnt_d;
  logic [2:0]         last_eng_q, last_eng_d;
  logic [7:0]         last_tag_q, last_tag_d;
  logic               ovf_q, ovf_d, to_q, to_d, bad_q, bad_d;
  logic               irq_en_q, irq_en_d, irq_q, irq_d;
  logic [TO_W-1:0]    to_thresh_q, to_thresh_d;
  logic [NUM_ENG-1:0] start_q, start_d;
  logic [7:0]         op_q, op_d;

  // Datapath storage (not reset)
  cmd_t               fifo_mem [QDEPTH];
  logic [7:0]         tag_q [NUM_ENG];

  // FIFO / dispatcher
  cmd_t               head;
  logic               fifo_empty, fifo_full, head_bad;
  logic               pop, disp, push, ovf_set;
  logic [7:0]         busy_ext;
  logic [NUM_ENG-1:0] disp_oh;

  assign head       = fifo_mem[rd_ptr_q];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(QDEPTH));
  assign head_bad   = {1'b0, head.eng} >= 4'(NUM_ENG);
  assign busy_ext   = 8'(busy_q);

  // The dispatcher looks at the registered busy bits only, so an engine that
  // completes at an edge can be restarted no earlier than the next edge.
  always_comb begin
    pop  = 1'b0;
    disp = 1'b0;
    if (!fifo_empty) begin
      if (head_bad) begin
        pop = 1'b1;
      end else if (!busy_ext[head.eng]) begin
        pop  = 1'b1;
        disp = 1'b1;
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves at the same edge.
  assign push    = wr_cmd && (!fifo_full || pop);
  assign ovf_set = wr_cmd && fifo_full && !pop;
  assign disp_oh = disp ? (NUM_ENG'(1) << head.eng) : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= cmd_t'(mmio_wdata[18:0]);
  end

  // Per-engine completion and watchdog. A done arriving on the same edge
  // the watchdog would fire counts as a normal completion.
  logic [NUM_ENG-1:0] done_fire, to_fire;
  logic [3:0]         n_done;
  logic               wd_on;

  assign wd_on = (to_thresh_q != '0);

  always_comb begin
    done_fire  = '0;
    to_fire    = '0;
    n_done     = '0;
    busy_d     = busy_q;
    last_eng_d = last_eng_q;
    last_tag_d = last_tag_q;
    for (int e = 0; e < NUM_ENG; e++) begin
      wd_d[e]      = wd_q[e];
      done_fire[e] = busy_q[e] & eng_done[e];
      to_fire[e]   = busy_q[e] & ~eng_done[e] & wd_on &
                     ((wd_q[e] + TO_W'(1)) == to_thresh_q);
      if (disp_oh[e])     wd_d[e] = '0;
      else if (busy_q[e]) wd_d[e] = wd_q[e] + TO_W'(1);
      // Ascending loop: the highest-indexed completing engine wins LAST_TAG.
      if (done_fire[e]) begin
        n_done     = n_done + 4'd1;
        last_eng_d = 3'(e);
        last_tag_d = tag_q[e];
      end
      if (done_fire[e] || to_fire[e]) busy_d[e] = 1'b0;
      if (disp_oh[e])                 busy_d[e] = 1'b1;
    end
  end

  // Counters, stickies, configuration; increments and sets beat clears.
  logic [32:0] done_sum;

  always_comb begin
    done_sum    = {1'b0, (clr_cnt ? 32'd0 : done_cnt_q)} + 33'(n_done);
    done_cnt_d  = done_sum[32] ? 32'hFFFF_FFFF : done_sum[31:0];
    ovf_d       = (ovf_q & ~clr_st) | ovf_set;
    to_d        = (to_q  & ~clr_st) | (|to_fire);
    bad_d       = (bad_q & ~clr_st) | (pop & head_bad);
    irq_en_d    = wr_irq_en ? mmio_wdata[0] : irq_en_q;
    to_thresh_d = wr_thresh ? mmio_wdata[TO_W-1:0] : to_thresh_q;
    irq_d       = irq_en_q & ((done_cnt_q != 32'd0) | ovf_q | to_q | bad_q);
    start_d     = disp_oh;
    op_d        = disp ? head.op : op_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      busy_q      <= '0;
      done_cnt_q  <= '0;
      last_eng_q  <= '0;
      last_tag_q  <= '0;
      ovf_q       <= 1'b0;
      to_q        <= 1'b0;
      bad_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
      to_thresh_q <= '0;
      start_q     <= '0;
      op_q        <= '0;
      for (int e = 0; e < NUM_ENG; e++) wd_q[e] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_cnt_q  <= done_cnt_d;
      last_eng_q  <= last_eng_d;
      last_tag_q  <= last_tag_d;
      ovf_q       <= ovf_d;
      to_q        <= to_d;
      bad_q       <= bad_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
      to_thresh_q <= to_thresh_d;
      start_q     <= start_d;
      op_q        <= op_d;
      for (int e = 0; e < NUM_ENG; e++) wd_q[e] <= wd_d[e];
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < NUM_ENG; e++) begin
      if (disp_oh[e]) tag_q[e] <= head.tag;
    end
  end

  assign eng_start  = start_q;
  assign eng_opcode = op_q;
  assign irq        = irq_q;

  // Combinational read mux
  always_comb begin
    mmio_rdata = '0;
    case (mmio_addr)
      A_STATUS: begin
        mmio_rdata[0]     = fifo_empty;
        mmio_rdata[1]     = fifo_full;
        mmio_rdata[15:8]  = busy_ext;
        mmio_rdata[23:16] = 8'(cnt_q);
        mmio_rdata[32]    = ovf_q;
        mmio_rdata[33]    = to_q;
        mmio_rdata[34]    = bad_q;
      end
      A_DCNT:   mmio_rdata[31:0]     = done_cnt_q;
      A_LTAG:   mmio_rdata[10:0]     = {last_eng_q, last_tag_q};
      A_IRQEN:  mmio_rdata[0]        = irq_en_q;
      A_THRESH: mmio_rdata[TO_W-1:0] = to_thresh_q;
      default:  mmio_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_sattn_cmd_dispatch.sv
// Testbench for sattn_cmd_dispatch: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based behavioural model.
module tb_sattn_cmd_dispatch;
  localparam int AW = 16, DW = 64, NE = 4, QD = 8, TW = 16;

  logic          clk, rstn, mmio_wen;
  logic [AW-1:0] mmio_addr;
  logic [DW-1:0] mmio_wdata, mmio_rdata;
  logic [NE-1:0] eng_start, eng_done;
  logic [7:0]    eng_opcode;
  logic          irq;

  sattn_cmd_dispatch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ENG(NE),
                       .QDEPTH(QD), .TO_W(TW)) dut (
    .clk(clk), .rstn(rstn), .mmio_wen(mmio_wen), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata), .eng_start(eng_start),
    .eng_opcode(eng_opcode), .eng_done(eng_done), .irq(irq));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [2:0] eng;
    logic [7:0] tag;
    logic [7:0] op;
  } cmd_t;

  cmd_t          mq[$];
  bit            m_busy [NE];
  int            m_age  [NE];
  logic [7:0]    m_tagr [NE];
  longint        m_dcnt;
  int            m_leng;
  logic [7:0]    m_ltag;
  bit            m_ovf, m_to, m_bad, m_ien, m_irq;
  int            m_th;
  logic [NE-1:0] m_start;
  logic [7:0]    m_op;

  function automatic void m_reset();
    mq.delete();
    for (int e = 0; e < NE; e++) begin
      m_busy[e] = 1'b0;
      m_age[e]  = 0;
    end
    m_dcnt = 0; m_leng = 0; m_ltag = 0;
    m_ovf = 0; m_to = 0; m_bad = 0; m_ien = 0; m_irq = 0;
    m_th = 0; m_start = '0; m_op = '0;
  endfunction

  function automatic void m_step();
    cmd_t          h, c;
    bit            popped = 0, disp = 0, ovf_s = 0, to_s = 0, bad_s = 0;
    bit            wr, clr_st, clr_dc, irq_next;
    bit            busy_pre [NE];
    int            ncomp = 0;
    int            sz_pre;
    logic [NE-1:0] st = '0;
    sz_pre = mq.size();
    for (int e = 0; e < NE; e++) busy_pre[e] = m_busy[e];
    irq_next = m_ien && (m_dcnt != 0 || m_ovf || m_to || m_bad);
    wr = (mmio_wen === 1'b1);
    // in-order head: discard bad engine, otherwise start if engine idle
    if (sz_pre > 0) begin
      h = mq[0];
      if (int'(h.eng) >= NE) begin
        mq.delete(0); popped = 1; bad_s = 1;
      end else if (!m_busy[h.eng]) begin
        mq.delete(0); popped = 1; disp = 1;
      end
    end
    for (int e = 0; e < NE; e++) begin
      if (busy_pre[e]) begin
        if (eng_done[e]) begin
          ncomp++; m_leng = e; m_ltag = m_tagr[e]; m_busy[e] = 0;
        end else if (m_th != 0 && ((m_age[e] + 1) % 65536) == m_th) begin
          m_busy[e] = 0; to_s = 1;
        end else begin
          m_age[e] = (m_age[e] + 1) % 65536;
        end
      end
    end
    if (disp) begin
      m_busy[h.eng] = 1; m_age[h.eng] = 0; m_tagr[h.eng] = h.tag;
      st[h.eng] = 1'b1; m_op = h.op;
    end
    if (wr && mmio_addr == 16'h00) begin
      if (sz_pre < QD || popped) begin
        c.eng = mmio_wdata[18:16]; c.tag = mmio_wdata[15:8]; c.op = mmio_wdata[7:0];
        mq.push_back(c);
      end else ovf_s = 1;
    end
    clr_st = wr && mmio_addr == 16'h28 && mmio_wdata[0];
    clr_dc = wr && mmio_addr == 16'h28 && mmio_wdata[1];
    m_dcnt = (clr_dc ? 0 : m_dcnt) + ncomp;
    if (m_dcnt > 64'hFFFF_FFFF) m_dcnt = 64'hFFFF_FFFF;
    m_ovf = (m_ovf && !clr_st) || ovf_s;
    m_to  = (m_to  && !clr_st) || to_s;
    m_bad = (m_bad && !clr_st) || bad_s;
    if (wr && mmio_addr == 16'h20) m_ien = mmio_wdata[0];
    if (wr && mmio_addr == 16'h30) m_th = int'(mmio_wdata[15:0]);
    m_irq   = irq_next;
    m_start = st;
  endfunction

  function automatic logic [63:0] m_read(logic [15:0] a);
    logic [63:0] r = '0;
    logic [7:0]  b = '0;
    case (a)
      16'h08: begin
        for (int e = 0; e < NE; e++) b[e] = m_busy[e];
        r = {29'd0, m_bad, m_to, m_ovf, 8'd0, 8'(mq.size()), b, 6'd0,
             (mq.size() == QD), (mq.size() == 0)};
      end
      16'h10:  r = 64'(m_dcnt);
      16'h18:  r = {53'd0, 3'(m_leng), m_ltag};
      16'h20:  r = {63'd0, m_ien};
      16'h30:  r = 64'(m_th);
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m_reset();
    else       m_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rstn && cmp_en) begin
      chk("eng_start", 64'(eng_start), 64'(m_start));
      if (m_start != '0) chk("eng_opcode", 64'(eng_opcode), 64'(m_op));
      chk("irq", 64'(irq), 64'(m_irq));
      chk($sformatf("rdata@%0h", mmio_addr), mmio_rdata, m_read(mmio_addr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    mmio_wen = 1'b0;
    eng_done = '0;
  endtask

  task automatic wr(logic [15:0] a, logic [63:0] d);
    mmio_wen = 1'b1; mmio_addr = a; mmio_wdata = d;
    cyc();
  endtask

  task automatic cmd(logic [2:0] e, logic [7:0] t, logic [7:0] o);
    wr(16'h00, {45'd0, e, t, o});
  endtask

  task automatic rd(string n, logic [15:0] a, logic [63:0] e);
    mmio_addr = a;
    #1;
    chk(n, mmio_rdata, e);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; mmio_wen = 1'b0; mmio_addr = '0; mmio_wdata = '0; eng_done = '0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    cmp_en = 1'b1;

    // reset state
    chk("rst_start", 64'(eng_start), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    rd("rst_status", 16'h08, 64'h1);
    rd("rst_dcnt", 16'h10, 64'h0);

    // single command to engine 0
    cmd(3'd0, 8'h01, 8'h14);
    chk("t1_nostart_yet", 64'(eng_start), 64'h0);
    cyc();
    chk("t1_start", 64'(eng_start), 64'h1);
    chk("t1_opcode", 64'(eng_opcode), 64'h14);
    rd("t1_status_busy", 16'h08, 64'h101);
    cyc();
    chk("t1_start_drop", 64'(eng_start), 64'h0);
    eng_done = 4'b0001;
    cyc();
    rd("t1_dcnt", 16'h10, 64'h1);
    rd("t1_ltag", 16'h18, 64'h001);
    rd("t1_status", 16'h08, 64'h1);

    // three commands to engine 1, head-of-line blocking
    wr(16'h28, 64'h2);
    cmd(3'd1, 8'h10, 8'h20);
    cmd(3'd1, 8'h11, 8'h21);
    chk("t2_first_start", 64'(eng_start), 64'h2);
    cmd(3'd1, 8'h12, 8'h22);
    chk("t2_no_second", 64'(eng_start), 64'h0);
    cyc();
    cyc();
    rd("t2_status_cnt2", 16'h08, 64'h0002_0200);
    for (int i = 0; i < 2; i++) begin
      eng_done = 4'b0010;
      cyc();
      chk("t2_gap", 64'(eng_start), 64'h0);
      cyc();
      chk("t2_next_start", 64'(eng_start), 64'h2);
      chk("t2_next_op", 64'(eng_opcode), 64'(8'h21 + 8'(i)));
      cyc();
    end
    eng_done = 4'b0010;
    cyc();
    rd("t2_dcnt", 16'h10, 64'h3);
    rd("t2_ltag", 16'h18, 64'h112);

    // back-to-back dispatch to three engines, simultaneous done
    wr(16'h28, 64'h2);
    cmd(3'd0, 8'h30, 8'h40);
    chk("t3_s0", 64'(eng_start), 64'h0);
    cmd(3'd1, 8'h31, 8'h41);
    chk("t3_s1", 64'(eng_start), 64'h1);
    cmd(3'd2, 8'h32, 8'h42);
    chk("t3_s2", 64'(eng_start), 64'h2);
    cyc();
    chk("t3_s3", 64'(eng_start), 64'h4);
    chk("t3_op", 64'(eng_opcode), 64'h42);
    eng_done = 4'b0111;
    cyc();
    rd("t3_dcnt", 16'h10, 64'h3);
    rd("t3_ltag", 16'h18, 64'h232);

    // overflow
    do_reset();
    cmd(3'd0, 8'h40, 8'h50);
    cyc();
    for (int i = 0; i < 8; i++) cmd(3'd0, 8'(8'h41 + i), 8'h51);
    rd("t4_full", 16'h08, 64'h0000_0000_0008_0102);
    cmd(3'd0, 8'h49, 8'h51);
    rd("t4_ovf", 16'h08, 64'h0000_0001_0008_0102);
    wr(16'h28, 64'h1);
    rd("t4_clr", 16'h08, 64'h0000_0000_0008_0102);

    // watchdog
    do_reset();
    wr(16'h30, 64'd10);
    wr(16'h20, 64'h1);
    cmd(3'd3, 8'h55, 8'h66);
    cyc();
    chk("t5_start", 64'(eng_start), 64'h8);
    rd("t5_busy0", 16'h08, 64'h801);
    repeat (9) cyc();
    rd("t5_busy9", 16'h08, 64'h801);
    cyc();
    rd("t5_timeout", 16'h08, 64'h2_0000_0001);
    chk("t5_irq_lag", 64'(irq), 64'h0);
    cyc();
    chk("t5_irq", 64'(irq), 64'h1);
    eng_done = 4'b1000;
    cyc();
    rd("t5_late_done", 16'h10, 64'h0);

    // bad engine, then asynchronous reset while busy
    do_reset();
    cmd(3'd5, 8'h77, 8'h88);
    cyc();
    chk("t6_nostart", 64'(eng_start), 64'h0);
    rd("t6_bad", 16'h08, 64'h4_0000_0001);
    wr(16'h20, 64'h1);
    wr(16'h30, 64'd100);
    cmd(3'd2, 8'h21, 8'h33);
    cyc();
    eng_done = 4'b0100;
    cyc();
    cmd(3'd0, 8'h01, 8'h02);
    cyc();
    chk("t6_start", 64'(eng_start), 64'h1);
    rd("t6_ltag", 16'h18, 64'h221);
    rstn = 1'b0;
    #1;
    chk("t6_async_start", 64'(eng_start), 64'h0);
    chk("t6_rst_irq", 64'(irq), 64'h0);
    rd("t6_rst_status", 16'h08, 64'h1);
    rd("t6_rst_dcnt", 16'h10, 64'h0);
    rd("t6_rst_ltag", 16'h18, 64'h0);
    rd("t6_rst_ien", 16'h20, 64'h0);
    rd("t6_rst_th", 16'h30, 64'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned r, ph;
      logic [15:0] ra [9];
      ra = '{16'h00, 16'h08, 16'h10, 16'h18, 16'h20, 16'h28, 16'h30, 16'h38, 16'h0C};
      r  = $urandom_range(0, 99);
      ph = (i / 500) % 3;
      mmio_wdata = {$urandom(), $urandom()};
      if (r < 35) begin
        mmio_wen = 1'b1; mmio_addr = 16'h00;
        mmio_wdata[18:16] = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7))
                                                         : 3'($urandom_range(0, 3));
      end else if (r < 38) begin
        mmio_wen = 1'b1; mmio_addr = 16'h28;
      end else if (r < 40) begin
        mmio_wen = 1'b1; mmio_addr = 16'h20;
      end else if (r < 42) begin
        mmio_wen = 1'b1; mmio_addr = 16'h30;
        mmio_wdata = 64'($urandom_range(0, 40));
      end else if (r < 44) begin
        mmio_wen = 1'b1; mmio_addr = ra[$urandom_range(1, 8)];
        if (mmio_addr == 16'h20 || mmio_addr == 16'h28 || mmio_addr == 16'h30)
          mmio_addr = 16'h38;
      end else begin
        mmio_addr = ra[$urandom_range(0, 8)];
      end
      for (int e = 0; e < NE; e++)
        eng_done[e] = ($urandom_range(0, (ph == 0) ? 3 : (ph == 1) ? 19 : 1) == 0);
      if (i == 1700) begin
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
      end else begin
        cyc();
      end
    end

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
